// File: rtl/mul_pkg.sv
// Shared definitions for the multi-cycle shift-add multiplier.
// Holds the operation mode encodings, FSM state encodings and the
// default iteration count used by mul_unit.
package mul_pkg;

  typedef enum logic [1:0] {
    MODE_MUL    = 2'b00,  // low word, signed x signed
    MODE_MULH   = 2'b01,  // high word, signed x signed
    MODE_MULHSU = 2'b10,  // high word, signed x unsigned
    MODE_MULHU  = 2'b11   // high word, unsigned x unsigned
  } mul_mode_e;

  // state      | meaning
  // ST_IDLE    | waiting for mul_valid; stalls the core if a request is present
  // ST_BUSY    | one shift-add step per cycle, MUL_CYCLES steps in total
  // ST_DONE    | single cycle, mul_ready high, result on mul_out
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mul_state_e;

  localparam int MUL_CYCLES_DEF = 32;

endpackage

// File: rtl/mul_negate64.sv
// Conditional two's-complement negation, purely combinational.
// Ports:
//   val  - input value
//   neg  - when 1, result = -val; otherwise result = val
//   res  - result
// The default width is 64 (final product sign fix); a 32-bit instance
// converts signed operands to magnitudes. -0x80000000 at 32 bits gives
// 0x80000000, which is exactly the correct unsigned magnitude.
module mul_negate64 #(
  parameter int W = 64
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/mul_unit.sv
// Iterative shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU group.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   mul_valid    - request from decode (held high while the core is stalled)
//   mul_mode     - operation select (see mul_pkg::mul_mode_e)
//   mul_in_a/b   - rs1 / rs2 operands
//   mul_ready    - one-cycle pulse in DONE, result valid on mul_out
//   mul_out      - selected 32-bit result word, held until the next accept
//   mul_stall    - pipeline freeze while a request is pending or in flight
// Operands are converted to magnitudes on accept; the unsigned product is
// built over MUL_CYCLES steps and the sign is restored at the last step.
module mul_unit
  import mul_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mul_valid,
  input  logic [1:0]  mul_mode,
  input  logic [31:0] mul_in_a,
  input  logic [31:0] mul_in_b,
  output logic        mul_ready,
  output logic [31:0] mul_out,
  output logic        mul_stall
);

  localparam int CW = $clog2(MUL_CYCLES) + 1;

  mul_state_e  state, state_next;
  logic [CW-1:0] cnt;
  logic [64:0] acc;        // 64-bit product plus carry
  logic [63:0] mcand;      // shifted left each step
  logic [31:0] mplier;     // shifted right each step
  mul_mode_e   mode_q;
  logic        neg_q;

  mul_mode_e   mode_in;
  logic        signed_a, signed_b;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b;
  logic [64:0] acc_step;
  logic [63:0] prod_fix;
  logic [31:0] out_sel;
  logic        last_step;
  logic        accept;

  assign mode_in  = mul_mode_e'(mul_mode);
  assign signed_a = (mode_in != MODE_MULHU);
  assign signed_b = (mode_in == MODE_MUL) || (mode_in == MODE_MULH);
  assign neg_a    = signed_a & mul_in_a[31];
  assign neg_b    = signed_b & mul_in_b[31];

  mul_negate64 #(.W(32)) u_mag_a (.val(mul_in_a), .neg(neg_a), .res(mag_a));
  mul_negate64 #(.W(32)) u_mag_b (.val(mul_in_b), .neg(neg_b), .res(mag_b));

  assign acc_step  = mplier[0] ? (acc + {1'b0, mcand}) : acc;
  assign last_step = (cnt == CW'(MUL_CYCLES - 1));
  assign accept    = (state == ST_IDLE) && mul_valid;

  // Sign fix is applied to the step result so the final word can be
  // registered on the same edge that enters DONE.
  mul_negate64 #(.W(64)) u_fix (.val(acc_step[63:0]), .neg(neg_q), .res(prod_fix));

  assign out_sel = (mode_q == MODE_MUL) ? prod_fix[31:0] : prod_fix[63:32];

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (mul_valid) state_next = ST_BUSY;
      ST_BUSY: if (last_step) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      mode_q  <= MODE_MUL;
      neg_q   <= 1'b0;
      mul_out <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        mode_q <= mode_in;
        neg_q  <= neg_a ^ neg_b;
        mcand  <= {32'b0, mag_a};
        mplier <= mag_b;
        acc    <= '0;
        cnt    <= '0;
      end else if (state == ST_BUSY) begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (last_step) mul_out <= out_sel;
      end
    end
  end

  assign mul_ready = (state == ST_DONE);
  // Gated by rst so the core is never frozen while reset is held.
  assign mul_stall = !rst && (accept || (state == ST_BUSY));

endmodule

// File: tb/tb_mul_unit.sv
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mul_valid;
  logic [1:0]  mul_mode;
  logic [31:0] mul_in_a;
  logic [31:0] mul_in_b;
  logic        mul_ready;
  logic [31:0] mul_out;
  logic        mul_stall;

  int tests = 0;
  int fails = 0;

  mul_unit dut (
    .clk       (clk),
    .rst       (rst),
    .mul_valid (mul_valid),
    .mul_mode  (mul_mode),
    .mul_in_a  (mul_in_a),
    .mul_in_b  (mul_in_b),
    .mul_ready (mul_ready),
    .mul_out   (mul_out),
    .mul_stall (mul_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one request for a single cycle, then scrambles the inputs so
  // the result must come from the latched operands.
  task automatic run_op(input string tag, input logic [1:0] m,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int lat;
    int stall_gap;
    @(negedge clk);
    mul_valid = 1'b1; mul_mode = m; mul_in_a = a; mul_in_b = b;
    #1;
    check({tag, " stall_req"}, 32'(mul_stall), 32'd1);
    lat = 0;
    stall_gap = 0;
    do begin
      @(negedge clk);
      if (lat == 0) begin
        mul_valid = 1'b0; mul_mode = ~m; mul_in_a = ~a; mul_in_b = b + 32'd17;
      end
      #1;
      lat++;
      if (!mul_ready && !mul_stall) stall_gap++;
    end while (!mul_ready && lat < 100);
    check({tag, " latency"}, 32'(lat), 32'd33);
    check({tag, " stall_gaps"}, 32'(stall_gap), 32'd0);
    check({tag, " result"}, mul_out, exp);
    check({tag, " stall_done"}, 32'(mul_stall), 32'd0);
    @(negedge clk); #1;
    check({tag, " ready_pulse"}, 32'(mul_ready), 32'd0);
    check({tag, " held"}, mul_out, exp);
  endtask

  initial begin
    int readies;
    int first_at;
    int second_at;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        idle_stall;

    rst = 1'b1; mul_valid = 1'b1; mul_mode = 2'b00;
    mul_in_a = 32'd3; mul_in_b = 32'd5;
    repeat (3) @(negedge clk);
    #1;
    check("rst stall", 32'(mul_stall), 32'd0);
    check("rst ready", 32'(mul_ready), 32'd0);
    check("rst out", mul_out, 32'd0);
    mul_valid = 1'b0;
    @(negedge clk); rst = 1'b0;

    run_op("mul_3x5",      2'b00, 32'd3,          32'd5,          32'h0000000F);
    run_op("mulh_min",     2'b01, 32'h80000000,   32'h80000000,   32'h40000000);
    run_op("mulh_m1",      2'b01, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000);
    run_op("mulhu_max",    2'b11, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE);
    run_op("mulhsu_max",   2'b10, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF);
    run_op("mul_shift",    2'b00, 32'h12345678,   32'h00000010,   32'h23456780);
    run_op("mulh_neg",     2'b01, 32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF);
    run_op("mulhu_2p32",   2'b11, 32'h80000000,   32'd2,          32'h00000001);

    // Back-to-back: valid held high; operands switch right after accept,
    // so the second op (6x7) is taken in the IDLE cycle after DONE.
    @(negedge clk);
    mul_valid = 1'b1; mul_mode = 2'b00; mul_in_a = 32'd3; mul_in_b = 32'd5;
    readies = 0; first_at = 0; second_at = 0; r1 = '0; r2 = '0; idle_stall = 1'b0;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (i == 1) begin mul_in_a = 32'd6; mul_in_b = 32'd7; end
      if (i == 40) begin mul_in_a = 32'd100; mul_in_b = 32'd100; end
      #1;
      if (i == 34) idle_stall = mul_stall;
      if (mul_ready) begin
        readies++;
        if (readies == 1) begin first_at = i; r1 = mul_out; end
        if (readies == 2) begin second_at = i; r2 = mul_out; mul_valid = 1'b0; end
      end
    end
    check("b2b ready_count", 32'(readies), 32'd2);
    check("b2b first_at", 32'(first_at), 32'd33);
    check("b2b first_res", r1, 32'h0000000F);
    check("b2b idle_stall", 32'(idle_stall), 32'd1);
    check("b2b second_at", 32'(second_at), 32'd67);
    check("b2b second_res", r2, 32'd42);

    // Reset during BUSY iteration 10, asserted away from the clock edge.
    @(negedge clk);
    mul_valid = 1'b1; mul_mode = 2'b11; mul_in_a = 32'h80000000; mul_in_b = 32'd4;
    @(negedge clk); mul_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2;
    check("pre_rst stall", 32'(mul_stall), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst stall", 32'(mul_stall), 32'd0);
    check("async_rst ready", 32'(mul_ready), 32'd0);
    check("async_rst out", mul_out, 32'd0);
    @(negedge clk); rst = 1'b0;
    readies = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (mul_ready) readies++;
    end
    check("abort no_ready", 32'(readies), 32'd0);
    check("abort out", mul_out, 32'd0);

    run_op("mul_7xm2", 2'b00, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_unit.md
MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst  input  1  asynchronous active-high reset.
REQ-004 Port: mul_valid  input  1  multiply request from decode; held high by the core while stalled.
REQ-005 Port: mul_mode  input  2  00 MUL (low word), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high).
REQ-006 Port: mul_in_a  input  32  rs1 operand.
REQ-007 Port: mul_in_b  input  32  rs2 operand.
REQ-008 Port: mul_ready  output  1  one-cycle pulse; result valid for the register-write select.
REQ-009 Port: mul_out  output  32  selected result word.
REQ-010 Port: mul_stall  output  1  freezes PC/pipeline while a multiply is pending.
REQ-011 Parameter: MUL_CYCLES, default 32, number of add-shift iterations.

Function
REQ-012 The block SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 IDLE: mul_valid sampled high at edge k SHALL latch mode and operand magnitudes, record the result sign, clear the 64-bit accumulator and iteration counter, and go to BUSY.
REQ-014 BUSY: each cycle SHALL perform one shift-add step (add multiplicand when the multiplier LSB is 1, then shift); after MUL_CYCLES steps it SHALL go to DONE.
REQ-015 DONE: one cycle only, mul_ready=1; next state IDLE unconditionally.
REQ-016 Latency: request at edge k SHALL give mul_ready high during cycle k+MUL_CYCLES+1 (cycle 33 for the default).
REQ-017 Signed handling: an operand is treated as signed for MUL/MULH (both), MULHSU (a only); a negative operand is converted to its magnitude; the 64-bit product is two's-complement negated iff exactly one signed operand was negative.
REQ-018 mul_out SHALL be product[31:0] for MUL and product[63:32] otherwise; it SHALL be held from DONE until the next request is accepted, and SHALL be 0 after reset.
REQ-019 mul_stall SHALL equal (IDLE and mul_valid) or BUSY; it SHALL be 0 in DONE so the instruction retires that cycle.
REQ-020 mul_valid in BUSY or DONE SHALL be ignored; operand/mode changes after acceptance SHALL NOT affect the result.
REQ-021 After DONE, a still-high mul_valid in IDLE SHALL start a new operation (back-to-back multiplies allowed, one idle cycle minimum).
REQ-022 Operand 0x80000000 signed SHALL yield magnitude 0x80000000 (33-bit-safe, no overflow).
REQ-023 Accumulator SHALL be 64 bits plus carry; no truncation before the final select.

Reset
REQ-024 rst high SHALL immediately force state IDLE, counter 0, accumulator 0, mul_out 0, mul_ready 0, mul_stall 0 (stall stays 0 while rst is high), regardless of clk.
REQ-025 Reset asserted mid-BUSY SHALL abort the operation; no mul_ready pulse SHALL follow deassertion unless a new request is accepted.

Structure
REQ-026 Package mul_pkg SHALL hold the mode encodings, state encodings, and MUL_CYCLES default.
REQ-027 One sub-module, mul_negate64 (combinational 64-bit conditional two's-complement), SHALL be used for the final sign fix; operand magnitude conversion may reuse a 32-bit instance of the same logic.
REQ-028 All state SHALL live in one clocked process; next-state and output decode SHALL be combinational.

Verification
REQ-029 MUL 3×5 at edge k -> mul_stall high cycles k..k+32, mul_ready single pulse at k+33, mul_out=0x0000000F.
REQ-030 MULH 0x80000000×0x80000000 -> 0x40000000; MULH 0xFFFFFFFF×0xFFFFFFFF -> 0x00000000.
REQ-031 MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032 mul_valid held high through DONE, operands changed mid-BUSY -> exactly one ready pulse per accepted request, results match the latched operands, second op starts in the IDLE cycle after DONE.
REQ-033 rst pulsed at BUSY iteration 10 -> outputs 0 asynchronously, no ready pulse, next MUL 7×(-2) returns 0xFFFFFFF2 with full latency.
